// File: rtl/apb_cfg_slave_pkg.sv
// Shared definitions for the accelerator configuration block: register offsets,
// STATUS bit positions and the APB completer state encoding.
package tpu_cfg_pkg;

    localparam int unsigned OFS_CTRL        = 32'h00;
    localparam int unsigned OFS_STATUS      = 32'h04;
    localparam int unsigned OFS_ADDR_A      = 32'h08;
    localparam int unsigned OFS_ADDR_B      = 32'h0C;
    localparam int unsigned OFS_ADDR_C      = 32'h10;
    localparam int unsigned OFS_CYCLE_COUNT = 32'h14;
    localparam int unsigned OFS_SCRATCH     = 32'h18;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;
    localparam int unsigned CTRL_START_BIT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_cfg_slave_if.sv
// APB bus between the host-side requester and the configuration completer.
// The requester drives address/control/write data; the completer returns PRDATA/PREADY.
interface apb_cfg_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_cfg_slave.sv
// APB config/status registers for the matmul core; commits once on the SETUP->ACCESS edge.
// Zero wait states (PREADY = PSEL & PENABLE); PRDATA registered and held until the next read.
module apb_cfg_slave
    import tpu_cfg_pkg::*;
#(
    parameter int REG_ADDRWIDTH = 8,
    parameter int REG_DATAWIDTH = 32,
    parameter int AWIDTH        = 10
) (
    input  logic              clk,
    input  logic              resetn,
    apb_cfg_slave_if.slave    apb,
    input  logic              done_i,
    output logic              start_o,
    output logic [AWIDTH-1:0] addr_a_o,
    output logic [AWIDTH-1:0] addr_b_o,
    output logic [AWIDTH-1:0] addr_c_o
);

    apb_state_t               state;
    apb_state_t               state_nxt;
    logic                     commit;
    logic                     wr_commit;
    logic                     rd_commit;

    logic                     sel_ctrl, sel_status, sel_a, sel_b, sel_c, sel_cnt, sel_scratch;
    logic [REG_DATAWIDTH-1:0] rd_mux;
    logic                     start_accept;
    logic                     done_clear;

    logic                     busy;
    logic                     done;
    logic [REG_DATAWIDTH-1:0] cycle_count;
    logic [REG_DATAWIDTH-1:0] scratch;
    logic [REG_DATAWIDTH-1:0] prdata;
    logic [AWIDTH-1:0]        addr_a;
    logic [AWIDTH-1:0]        addr_b;
    logic [AWIDTH-1:0]        addr_c;

    assign apb.PREADY = apb.PSEL & apb.PENABLE;
    assign apb.PRDATA = prdata;
    assign addr_a_o   = addr_a;
    assign addr_b_o   = addr_b;
    assign addr_c_o   = addr_c;

    // An access phase seen straight from IDLE is a protocol violation: track it, never commit.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (apb.PSEL && apb.PENABLE)  state_nxt = ST_ACCESS;
                else if (apb.PSEL)            state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (!apb.PSEL) begin
                    state_nxt = ST_IDLE;
                end else if (apb.PENABLE) begin
                    state_nxt = ST_ACCESS;
                    commit    = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!apb.PSEL)                state_nxt = ST_IDLE;
                else if (!apb.PENABLE)        state_nxt = ST_SETUP;
            end
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    assign wr_commit = commit &  apb.PWRITE;
    assign rd_commit = commit & ~apb.PWRITE;

    // Misaligned offsets never match a case item, so they fall through as unmapped.
    always_comb begin
        sel_ctrl    = 1'b0;
        sel_status  = 1'b0;
        sel_a       = 1'b0;
        sel_b       = 1'b0;
        sel_c       = 1'b0;
        sel_cnt     = 1'b0;
        sel_scratch = 1'b0;
        rd_mux      = '0;
        case (apb.PADDR)
            REG_ADDRWIDTH'(OFS_CTRL):        sel_ctrl = 1'b1;
            REG_ADDRWIDTH'(OFS_STATUS): begin
                sel_status               = 1'b1;
                rd_mux[STATUS_BUSY_BIT]  = busy;
                rd_mux[STATUS_DONE_BIT]  = done;
            end
            REG_ADDRWIDTH'(OFS_ADDR_A): begin
                sel_a  = 1'b1;
                rd_mux = REG_DATAWIDTH'(addr_a);
            end
            REG_ADDRWIDTH'(OFS_ADDR_B): begin
                sel_b  = 1'b1;
                rd_mux = REG_DATAWIDTH'(addr_b);
            end
            REG_ADDRWIDTH'(OFS_ADDR_C): begin
                sel_c  = 1'b1;
                rd_mux = REG_DATAWIDTH'(addr_c);
            end
            REG_ADDRWIDTH'(OFS_CYCLE_COUNT): begin
                sel_cnt = 1'b1;
                rd_mux  = cycle_count;
            end
            REG_ADDRWIDTH'(OFS_SCRATCH): begin
                sel_scratch = 1'b1;
                rd_mux      = scratch;
            end
            default: ;
        endcase
    end

    // Start uses the pre-edge busy, so a coincident done_i cannot re-arm a second pulse.
    assign start_accept = wr_commit & sel_ctrl & apb.PWDATA[CTRL_START_BIT] & ~busy;
    assign done_clear   = wr_commit & sel_status & apb.PWDATA[STATUS_DONE_BIT];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            start_o     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
            scratch     <= '0;
            prdata      <= '0;
            addr_a      <= '0;
            addr_b      <= '0;
            addr_c      <= '0;
        end else begin
            state   <= state_nxt;
            start_o <= start_accept;

            if (start_accept)      busy <= 1'b1;
            else if (done_i)       busy <= 1'b0;

            if (done_i)            done <= 1'b1;
            else if (done_clear)   done <= 1'b0;

            if (start_accept)                    cycle_count <= '0;
            else if (busy && (cycle_count != '1)) cycle_count <= cycle_count + 1'b1;

            if (wr_commit) begin
                if (sel_a)       addr_a  <= apb.PWDATA[AWIDTH-1:0];
                if (sel_b)       addr_b  <= apb.PWDATA[AWIDTH-1:0];
                if (sel_c)       addr_c  <= apb.PWDATA[AWIDTH-1:0];
                if (sel_scratch) scratch <= apb.PWDATA;
            end

            if (rd_commit) prdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_apb_cfg_slave.sv
// Self-checking bench for apb_cfg_slave: register table plus start/done, hold and reset sequences.
module tb_apb_cfg_slave;
    import tpu_cfg_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic       done_i;
    logic       start_o;
    logic [9:0] addr_a_o, addr_b_o, addr_c_o;

    apb_cfg_slave_if #(.ADDR_W(8), .DATA_W(32)) apb ();

    apb_cfg_slave #(.REG_ADDRWIDTH(8), .REG_DATAWIDTH(32), .AWIDTH(10)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .apb      (apb),
        .done_i   (done_i),
        .start_o  (start_o),
        .addr_a_o (addr_a_o),
        .addr_b_o (addr_b_o),
        .addr_c_o (addr_c_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_pulses = 0;
    int start_consec = 0;
    logic prev_start = 1'b0;
    logic [31:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start_o === 1'b1) begin
            start_pulses++;
            if (prev_start === 1'b1) start_consec++;
        end
        prev_start = start_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer; the access phase lasts `hold` cycles and PWDATA switches to
    // late_wdata after the first of them, so any re-commit would be visible.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input int hold, input logic [31:0] late_wdata, input logic done_pulse);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = addr; apb.PWDATA = wdata;
        @(negedge clk);
        check("pready_setup", {31'b0, apb.PREADY}, 32'h0);
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        done_i = done_pulse;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check($sformatf("pready_access%0d", i), {31'b0, apb.PREADY}, 32'h1);
            @(posedge clk); #1;
            done_i = 1'b0;
            apb.PWDATA = late_wdata;
        end
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        apb_xfer(1'b1, addr, data, 1, data, 1'b0);
    endtask

    task automatic apb_read_raw(input logic [7:0] addr, output logic [31:0] data);
        apb_xfer(1'b0, addr, 32'h0, 1, 32'h0, 1'b0);
        @(negedge clk);
        data = apb.PRDATA;
    endtask

    // Expected value is queued at drive time and retired once PENABLE has fallen.
    task automatic apb_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] got;
        sb.push_back(exp);
        apb_read_raw(addr, got);
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty, got 0x%08h", name, got);
        end else begin
            check(name, got, sb.pop_front());
        end
    endtask

    task automatic pulse_done();
        @(posedge clk); #1; done_i = 1'b1;
        @(posedge clk); #1; done_i = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[18];
    logic [31:0] val;
    int start_cyc;

    initial begin
        resetn = 1'b0; done_i = 1'b0;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_prdata", apb.PRDATA, 32'h0);
        check("rst_start", {31'b0, start_o}, 32'h0);
        check("rst_addr_a", {22'b0, addr_a_o}, 32'h0);
        check("rst_pready", {31'b0, apb.PREADY}, 32'h0);

        tbl[0]  = '{1'b1, 8'h08, 32'h0000_0123, 32'h0};
        tbl[1]  = '{1'b0, 8'h08, 32'h0,         32'h0000_0123};
        tbl[2]  = '{1'b1, 8'h0C, 32'h0000_03FF, 32'h0};
        tbl[3]  = '{1'b0, 8'h0C, 32'h0,         32'h0000_03FF};
        tbl[4]  = '{1'b1, 8'h10, 32'hFFFF_F7FF, 32'h0};
        tbl[5]  = '{1'b0, 8'h10, 32'h0,         32'h0000_03FF};
        tbl[6]  = '{1'b1, 8'h18, 32'h1234_5678, 32'h0};
        tbl[7]  = '{1'b0, 8'h18, 32'h0,         32'h1234_5678};
        tbl[8]  = '{1'b0, 8'h1C, 32'h0,         32'h0};
        tbl[9]  = '{1'b0, 8'h18, 32'h0,         32'h1234_5678};
        tbl[10] = '{1'b0, 8'h05, 32'h0,         32'h0};
        tbl[11] = '{1'b1, 8'h1C, 32'hFFFF_FFFF, 32'h0};
        tbl[12] = '{1'b1, 8'h09, 32'h0000_0ABC, 32'h0};
        tbl[13] = '{1'b0, 8'h08, 32'h0,         32'h0000_0123};
        tbl[14] = '{1'b0, 8'h18, 32'h0,         32'h1234_5678};
        tbl[15] = '{1'b0, 8'h00, 32'h0,         32'h0};
        tbl[16] = '{1'b0, 8'h14, 32'h0,         32'h0};
        tbl[17] = '{1'b0, 8'h04, 32'h0,         32'h0};

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].wdata);
            else           apb_read(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_rd_%02h", i, tbl[i].addr));
        end
        @(negedge clk);
        check("addr_a_o", {22'b0, addr_a_o}, 32'h123);
        check("addr_b_o", {22'b0, addr_b_o}, 32'h3FF);
        check("addr_c_o", {22'b0, addr_c_o}, 32'h3FF);

        // Start, run 20 busy cycles, done, W1C.
        apb_write(8'h00, 32'h1);
        start_cyc = cyc;
        @(negedge clk); check("start_pulse", {31'b0, start_o}, 32'h1);
        @(negedge clk); check("start_low", {31'b0, start_o}, 32'h0);
        apb_read(8'h04, 32'h1, "status_busy");
        while (cyc < start_cyc + 19) begin @(posedge clk); #1; end
        done_i = 1'b1;
        @(posedge clk); #1; done_i = 1'b0;
        apb_read(8'h04, 32'h2, "status_done");
        apb_read_raw(8'h14, val);
        checks++;
        if (val < 32'd19 || val > 32'd21) begin
            failures++;
            $display("FAIL cycle_count: got %0d expected 20 +/-1", val);
        end
        apb_write(8'h04, 32'h2);
        apb_read(8'h04, 32'h0, "status_w1c");

        // Start while busy is ignored and leaves the counter running.
        apb_write(8'h00, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        apb_write(8'h00, 32'h1);
        @(negedge clk); check("busy_nostart0", {31'b0, start_o}, 32'h0);
        @(negedge clk); check("busy_nostart1", {31'b0, start_o}, 32'h0);
        apb_read_raw(8'h14, val);
        checks++;
        if (val < 32'd12) begin
            failures++;
            $display("FAIL busy_cnt_kept: got %0d expected >= 12", val);
        end
        pulse_done();
        apb_write(8'h04, 32'h2);
        apb_read(8'h04, 32'h0, "status_idle");

        // done_i on the same edge as an accepted start.
        apb_xfer(1'b1, 8'h00, 32'h1, 1, 32'h1, 1'b1);
        @(negedge clk); check("start_with_done", {31'b0, start_o}, 32'h1);
        apb_read(8'h04, 32'h3, "status_busy_done");
        pulse_done();
        apb_read(8'h04, 32'h2, "status_after_done");
        // W1C coinciding with done_i: set wins.
        apb_xfer(1'b1, 8'h04, 32'h2, 1, 32'h2, 1'b1);
        apb_read(8'h04, 32'h2, "w1c_vs_done");
        apb_write(8'h04, 32'h2);
        apb_read(8'h04, 32'h0, "w1c_plain");

        // Held access phase commits exactly once.
        apb_xfer(1'b1, 8'h18, 32'hDEAD_BEEF, 3, 32'h0BAD_F00D, 1'b0);
        apb_read(8'h18, 32'hDEAD_BEEF, "scratch_hold");

        // Access phase straight from idle is not committed.
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b1;
        apb.PADDR = 8'h18; apb.PWDATA = 32'h1111_1111;
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        apb_read(8'h18, 32'hDEAD_BEEF, "scratch_no_setup");

        // Reset during the access phase of an ADDR_B write.
        pulse_done();
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = 8'h0C; apb.PWDATA = 32'h55;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1; resetn = 1'b0;
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; resetn = 1'b1;
        @(negedge clk);
        check("rst2_prdata", apb.PRDATA, 32'h0);
        check("rst2_addr_a", {22'b0, addr_a_o}, 32'h0);
        check("rst2_addr_b", {22'b0, addr_b_o}, 32'h0);
        check("rst2_addr_c", {22'b0, addr_c_o}, 32'h0);
        check("rst2_start", {31'b0, start_o}, 32'h0);
        apb_read(8'h0C, 32'h0, "rst2_rd_addr_b");
        apb_read(8'h04, 32'h0, "rst2_rd_status");
        apb_read(8'h18, 32'h0, "rst2_rd_scratch");

        check("start_pulse_count", start_pulses, 32'd3);
        check("start_consecutive", start_consec, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_cfg_slave.md
Name: apb_cfg_slave

Overview:
- APB completer (slave) holding the accelerator's configuration and status registers.
- Responds to the host-side APB write/read sequences:
  - setup cycle: PSEL=1, PENABLE=0;
  - access cycle: PSEL=1, PENABLE=1;
  - then PSEL and PENABLE deasserted.
- Drives start and base-address controls into the matmul core.
- Captures done/busy status and a busy-cycle counter for readback.

Parameters:
- REG_ADDRWIDTH, 8, APB address width (byte addresses, word-aligned).
- REG_DATAWIDTH, 32, APB data width.
- AWIDTH, 10, BRAM address width of the A/B/C base-address registers.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  synchronous active-low reset.
- PADDR  input  REG_ADDRWIDTH  APB address.
- PWRITE  input  1  1=write, 0=read.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB enable (access phase).
- PWDATA  input  REG_DATAWIDTH  write data.
- PRDATA  output  REG_DATAWIDTH  read data, registered.
- PREADY  output  1  transfer-complete indication.
- done_i  input  1  one-cycle pulse from core at end of operation.
- start_o  output  1  one-cycle start pulse to core.
- addr_a_o  output  AWIDTH  base address A.
- addr_b_o  output  AWIDTH  base address B.
- addr_c_o  output  AWIDTH  base address C.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - All registers and outputs go to 0: PRDATA=0, start_o=0, addr_*_o=0, busy=0, done=0, cycle_count=0.
  - FSM goes to IDLE.
  - Reset mid-transfer aborts it; no partial write is committed.
- FSM states:
  - IDLE: PSEL=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- FSM transitions:
  - IDLE -> SETUP on PSEL & !PENABLE.
  - SETUP -> ACCESS on PSEL & PENABLE.
  - ACCESS -> IDLE on !PSEL.
  - ACCESS -> SETUP on PSEL & !PENABLE (back-to-back transfer).
  - PSEL & PENABLE seen while in IDLE (protocol violation) -> go to ACCESS without committing.
- PREADY = PSEL & PENABLE, combinational; zero wait states.
- Commit rule: a write or read takes effect exactly once, on the SETUP->ACCESS edge. Holding PENABLE for extra cycles does not re-commit.
- Reads:
  - PRDATA loads on the commit edge.
  - PRDATA holds its value until the next read commit, so the master may sample it after PENABLE falls.
  - Writes do not alter PRDATA.
- Register map (byte offsets):
  - 0x00 CTRL (WO, reads 0):
    - Writing bit0=1 while busy=0 gives start_o=1 for exactly the next cycle, sets busy=1, clears cycle_count.
    - Write with busy=1 is ignored.
  - 0x04 STATUS: bit0 busy (RO); bit1 done (sticky). Writing 1 to bit1 clears done (W1C).
  - 0x08 ADDR_A, 0x0C ADDR_B, 0x10 ADDR_C (RW):
    - Low AWIDTH bits are stored; upper read bits are 0.
    - Values drive addr_*_o directly, with 1-cycle latency after commit.
  - 0x14 CYCLE_COUNT (RO): increments every cycle while busy=1; saturates at all-ones.
  - 0x18 SCRATCH (RW): full width.
  - Unmapped or misaligned address: write ignored, read returns 0.
- done_i:
  - done_i while busy=1: busy<=0, done<=1.
  - done_i while busy=0: done<=1 only.
- Simultaneous events:
  - done_i on the same edge as a START commit: START is evaluated with the pre-edge busy value. If the start is accepted, busy stays 1 and done is set.
  - done_i on the same edge as a STATUS W1C: set wins, done stays 1.
- start_o is never high for two consecutive cycles.

Decomposition:
- Shared package tpu_cfg_pkg holds:
  - register offset localparams (CTRL, STATUS, ADDR_A, ADDR_B, ADDR_C, CYCLE_COUNT, SCRATCH);
  - STATUS bit indices;
  - the APB FSM state enum.
- No sub-module needed. The saturating cycle counter stays inline (about 10 lines).

Test Plan:
- Write 0x08=0x0000_0123, then read 0x08 -> PRDATA=0x0000_0123 held after PENABLE falls; addr_a_o=0x123. Repeat for 0x0C and 0x10 with 0x3FF -> readback 0x0000_03FF.
- Write 0x00=1 -> start_o high exactly one cycle; STATUS reads 0x1. Pulse done_i after 20 cycles -> STATUS=0x2, CYCLE_COUNT=20±1. Write STATUS=0x2 -> STATUS=0x0.
- Write 0x00=1 while busy=1 -> no start_o pulse, cycle_count not cleared. done_i on the same edge as a START commit with busy=0 -> start_o pulses, STATUS=0x3.
- Hold PSEL=PENABLE=1 for 3 cycles on a SCRATCH write of 0xDEAD_BEEF -> single commit, readback 0xDEAD_BEEF; PREADY high in all 3 access cycles.
- Read 0x1C and 0x05 -> PRDATA=0; write 0x1C=0xFFFF_FFFF -> no register changes.
- Assert resetn=0 during the access phase of an ADDR_B write of 0x55 -> after reset ADDR_B reads 0, FSM IDLE, all outputs 0.
